// File: rtl/fm_synth_pkg.sv
// Shared types and constants for the phase demodulator.
// Define PHASE_DEMOD_ROUND_EN to round the quotient half-up (one extra divide step).
package fm_synth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    CALC,
    DIV,
    DONE
  } state_e;

  // mod_scalar is U4.4
  localparam int MOD_SCALAR_WF = 4;

`ifdef PHASE_DEMOD_ROUND_EN
  localparam int ROUND_EN = 1;
`else
  localparam int ROUND_EN = 0;
`endif

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, DVD_W cycles after start.
// done_o is high during the cycle that produces the last quotient bit.
module seq_divider #(
  parameter int DVD_W = 48,
  parameter int DVS_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             done_o,
  output logic [DVD_W-1:0] quotient_o
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [DVD_W-1:0] quo_q, quo_d;
  logic [DVS_W:0]   rem_shift;
  logic             fits;

  // Remainder stays below the divisor, so the shifted value fits in DVS_W+1 bits.
  assign rem_shift = {rem_q, quo_q[DVD_W-1]};
  assign fits      = rem_shift >= {1'b0, dvs_q};
  assign done_o    = busy_q && (cnt_q == CNT_W'(1));
  assign quotient_o = quo_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(DVD_W);
      rem_d  = '0;
      dvs_d  = divisor_i;
      quo_d  = dividend_i;
    end else if (busy_q) begin
      rem_d = fits ? DVS_W'(rem_shift - {1'b0, dvs_q}) : rem_shift[DVS_W-1:0];
      quo_d = {quo_q[DVD_W-2:0], fits};
      cnt_d = cnt_q - CNT_W'(1);
      if (done_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
    end
  end

endmodule

// File: rtl/phase_demodulate.sv
// Recovers the modulating signal from successive phase samples: (dphase - tw) / (tw * depth).
// Optional PHASE_DEMOD_ROUND_EN rounds the magnitude half-up instead of truncating.
module phase_demodulate
  import fm_synth_pkg::*;
#(
  parameter int NUM_BITS = 32,
  parameter int WI       = 2,
  parameter int WF       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] tuning_word,
  input  logic [7:0]          mod_scalar,
  input  logic [NUM_BITS-1:0] phase_in,
  input  logic                phase_valid,
  output logic                phase_ready,
  output logic [WI+WF-1:0]    mod_signal,
  output logic                mod_valid,
  output logic                sat,
  output logic                div_err
);

  localparam int W      = WI + WF;
  localparam int DVD_W  = NUM_BITS + WF + ROUND_EN;
  localparam int PROD_W = NUM_BITS + 8;
  localparam logic [DVD_W:0] LIM = (DVD_W+1)'(1) << (W - 1);

  state_e              state_q, state_d;
  logic                primed_q, primed_d;
  logic [NUM_BITS-1:0] prev_phase_q, prev_phase_d;
  logic [NUM_BITS-1:0] delta_q, delta_d;
  logic                dev_neg_q, dev_neg_d;
  logic                div_zero_q, div_zero_d;
  logic [W-1:0]        mod_signal_q, mod_signal_d;
  logic                sat_q, sat_d, div_err_q, div_err_d, mod_valid_q, mod_valid_d;

  logic [NUM_BITS-1:0] deviation, dev_mag, denom;
  logic [PROD_W-1:0]   product, scaled;
  logic                div_start, div_done;
  logic [DVD_W-1:0]    quotient;
  logic [DVD_W:0]      mag_r;
  logic [W-1:0]        clip_sig;
  logic                clip_sat;

  assign deviation = delta_q - tuning_word;
  assign dev_mag   = deviation[NUM_BITS-1] ? (~deviation + NUM_BITS'(1)) : deviation;
  assign product   = PROD_W'(tuning_word) * PROD_W'(mod_scalar);
  assign scaled    = product >> MOD_SCALAR_WF;
  assign denom     = (|scaled[PROD_W-1:NUM_BITS]) ? '1 : scaled[NUM_BITS-1:0];

  seq_divider #(.DVD_W(DVD_W), .DVS_W(NUM_BITS)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i ({dev_mag, {(WF + ROUND_EN){1'b0}}}),
    .divisor_i  (denom),
    .done_o     (div_done),
    .quotient_o (quotient)
  );

  // Magnitude is rounded (if enabled) before the sign is applied and the result clipped.
  always_comb begin
    mag_r    = (ROUND_EN != 0) ? (({1'b0, quotient} + (DVD_W+1)'(1)) >> 1) : {1'b0, quotient};
    clip_sat = 1'b0;
    if (!dev_neg_q) begin
      clip_sig = mag_r[W-1:0];
      if (mag_r >= LIM) begin
        clip_sig = {1'b0, {(W-1){1'b1}}};
        clip_sat = 1'b1;
      end
    end else begin
      clip_sig = ~mag_r[W-1:0] + W'(1);
      if (mag_r > LIM) begin
        clip_sig = {1'b1, {(W-1){1'b0}}};
        clip_sat = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    primed_d     = primed_q;
    prev_phase_d = prev_phase_q;
    delta_d      = delta_q;
    dev_neg_d    = dev_neg_q;
    div_zero_d   = div_zero_q;
    mod_signal_d = mod_signal_q;
    sat_d        = sat_q;
    div_err_d    = div_err_q;
    mod_valid_d  = 1'b0;
    div_start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (phase_valid) begin
          prev_phase_d = phase_in;
          if (primed_q) begin
            delta_d = phase_in - prev_phase_q;
            state_d = CALC;
          end else begin
            primed_d = 1'b1;
            state_d  = PRIME;
          end
        end
      end
      PRIME: state_d = IDLE;
      CALC: begin
        dev_neg_d  = deviation[NUM_BITS-1];
        div_zero_d = (denom == '0);
        if (denom == '0) begin
          state_d = DONE;
        end else begin
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: if (div_done) state_d = DONE;
      DONE: begin
        mod_valid_d = 1'b1;
        if (div_zero_q) begin
          mod_signal_d = '0;
          sat_d        = 1'b0;
          div_err_d    = 1'b1;
        end else begin
          mod_signal_d = clip_sig;
          sat_d        = clip_sat;
          div_err_d    = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      primed_q     <= 1'b0;
      prev_phase_q <= '0;
      delta_q      <= '0;
      dev_neg_q    <= 1'b0;
      div_zero_q   <= 1'b0;
      mod_signal_q <= '0;
      sat_q        <= 1'b0;
      div_err_q    <= 1'b0;
      mod_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      primed_q     <= primed_d;
      prev_phase_q <= prev_phase_d;
      delta_q      <= delta_d;
      dev_neg_q    <= dev_neg_d;
      div_zero_q   <= div_zero_d;
      mod_signal_q <= mod_signal_d;
      sat_q        <= sat_d;
      div_err_q    <= div_err_d;
      mod_valid_q  <= mod_valid_d;
    end
  end

  assign phase_ready = (state_q == IDLE);
  assign mod_signal  = mod_signal_q;
  assign mod_valid   = mod_valid_q;
  assign sat         = sat_q;
  assign div_err     = div_err_q;

endmodule

// File: tb/tb_phase_demodulate.sv
// Table-driven scoreboard bench for phase_demodulate at NUM_BITS=32, WI=2, WF=16.
module tb_phase_demodulate;

  localparam int NB = 32;
  localparam int WF = 16;
  localparam int W  = 18;
`ifdef PHASE_DEMOD_ROUND_EN
  localparam int LAT = NB + WF + 4;
  localparam logic [W-1:0] TWO_THIRDS = 18'h0AAAB;
`else
  localparam int LAT = NB + WF + 3;
  localparam logic [W-1:0] TWO_THIRDS = 18'h0AAAA;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] tuning_word, phase_in;
  logic [7:0]    mod_scalar;
  logic          phase_valid, phase_ready, mod_valid, sat, div_err;
  logic [W-1:0]  mod_signal;

  phase_demodulate dut (
    .clk         (clk),
    .rst         (rst),
    .tuning_word (tuning_word),
    .mod_scalar  (mod_scalar),
    .phase_in    (phase_in),
    .phase_valid (phase_valid),
    .phase_ready (phase_ready),
    .mod_signal  (mod_signal),
    .mod_valid   (mod_valid),
    .sat         (sat),
    .div_err     (div_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] phase;
    logic [NB-1:0] tw;
    logic [7:0]    ms;
    bit            out;
    logic [W-1:0]  sig;
    logic          sat;
    logic          err;
  } vec_t;

  typedef struct {
    logic [W-1:0] sig;
    logic         sat;
    logic         err;
    int           lat;
  } exp_t;

  exp_t         sb_q[$];
  vec_t         vecs[11];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] last_sig = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    bit   seen;
    int   lat;
    @(negedge clk);
    check({tag, " ready"}, 64'(phase_ready), 64'd1);
    check({tag, " held mod_signal"}, 64'(mod_signal), 64'(last_sig));
    tuning_word = v.tw;
    mod_scalar  = v.ms;
    phase_in    = v.phase;
    phase_valid = 1'b1;
    if (v.out) begin
      e.sig = v.sig;
      e.sat = v.sat;
      e.err = v.err;
      e.lat = v.err ? 3 : LAT;
      sb_q.push_back(e);
    end
    @(posedge clk);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= LAT + 10; k++) begin
      @(negedge clk);
      if (k == 1) phase_valid = 1'b0;
      // Inputs must be ignored once CALC has passed
      if (k == 3) begin
        tuning_word = $urandom;
        mod_scalar  = 8'($urandom);
      end
      if (mod_valid) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
    if (v.out) begin
      e = sb_q.pop_front();
      check({tag, " mod_valid seen"}, 64'(seen), 64'd1);
      if (seen) begin
        check({tag, " latency"}, 64'(lat), 64'(e.lat));
        check({tag, " mod_signal"}, 64'(mod_signal), 64'(e.sig));
        check({tag, " sat"}, 64'(sat), 64'(e.sat));
        check({tag, " div_err"}, 64'(div_err), 64'(e.err));
        last_sig = e.sig;
        @(negedge clk);
        check({tag, " mod_valid pulse"}, 64'(mod_valid), 64'd0);
      end
    end else begin
      check({tag, " no mod_valid"}, 64'(seen), 64'd0);
    end
    $display("%s phase=%08h tw=%08h ms=%02h -> valid=%0d sig=%05h sat=%0d err=%0d lat=%0d",
             tag, v.phase, v.tw, v.ms, seen, mod_signal, sat, div_err, lat);
  endtask

  initial begin
    vec_t v;
    bit   seen;
    vecs[0]  = '{32'h00000000, 32'h01000000, 8'h10, 1'b0, 18'h00000, 1'b0, 1'b0};
    vecs[1]  = '{32'h01000000, 32'h01000000, 8'h10, 1'b1, 18'h00000, 1'b0, 1'b0};
    vecs[2]  = '{32'h02800000, 32'h01000000, 8'h10, 1'b1, 18'h08000, 1'b0, 1'b0};
    vecs[3]  = '{32'h03000000, 32'h01000000, 8'h10, 1'b1, 18'h38000, 1'b0, 1'b0};
    vecs[4]  = '{32'hFF800000, 32'h01000000, 8'h10, 1'b1, 18'h20000, 1'b1, 1'b0};
    vecs[5]  = '{32'h00800000, 32'h01000000, 8'h10, 1'b1, 18'h00000, 1'b0, 1'b0};
    vecs[6]  = '{32'h02000000, 32'h01000000, 8'h01, 1'b1, 18'h1FFFF, 1'b1, 1'b0};
    vecs[7]  = '{32'h03000000, 32'h01000000, 8'h00, 1'b1, 18'h00000, 1'b0, 1'b1};
    vecs[8]  = '{32'h03C00000, 32'h01000000, 8'h20, 1'b1, 18'h3E000, 1'b0, 1'b0};
    vecs[9]  = '{32'h06C00000, 32'h01000000, 8'h30, 1'b1, TWO_THIRDS,  1'b0, 1'b0};
    vecs[10] = '{32'h86BFFFFF, 32'hFFFFFFFF, 8'hFF, 1'b1, 18'h38000, 1'b0, 1'b0};

    rst = 1'b1; phase_valid = 1'b0; phase_in = '0; tuning_word = '0; mod_scalar = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset phase_ready", 64'(phase_ready), 64'd1);
    check("reset mod_valid", 64'(mod_valid), 64'd0);
    check("reset mod_signal", 64'(mod_signal), 64'd0);
    check("reset sat", 64'(sat), 64'd0);
    check("reset div_err", 64'(div_err), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset ten cycles into the division: no result, next accept only primes
    @(negedge clk);
    tuning_word = 32'h01000000; mod_scalar = 8'h10; phase_in = 32'h00000000; phase_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) phase_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst mod_signal", 64'(mod_signal), 64'd0);
    check("midrst sat", 64'(sat), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < LAT + 10; k++) begin
      @(negedge clk);
      if (mod_valid) seen = 1'b1;
    end
    check("midrst no mod_valid", 64'(seen), 64'd0);
    $display("midrst abort -> valid=%0d sig=%05h", seen, mod_signal);
    last_sig = '0;
    v = '{32'h01000000, 32'h01000000, 8'h10, 1'b0, 18'h00000, 1'b0, 1'b0};
    apply(v, "midrst prime");
    v = '{32'h02800000, 32'h01000000, 8'h10, 1'b1, 18'h08000, 1'b0, 1'b0};
    apply(v, "midrst follow");

    check("scoreboard empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_demodulate.md
PHASE_DEMODULATE -- requirements
Module: phase_demodulate

Interface
REQ-001 SHALL have parameter NUM_BITS, default 32, phase and tuning-word width.
REQ-002 SHALL have parameter WI, default 2, integer bits of recovered signal (signed two's complement).
REQ-003 SHALL have parameter WF, default 16, fractional bits of recovered signal.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port tuning_word  input  NUM_BITS  unmodulated carrier tuning word, unsigned.
REQ-007 SHALL have port mod_scalar  input  8  modulation depth, unsigned U4.4.
REQ-008 SHALL have port phase_in  input  NUM_BITS  accumulated phase sample, unsigned, wraps mod 2^NUM_BITS.
REQ-009 SHALL have port phase_valid  input  1  phase_in valid.
REQ-010 SHALL have port phase_ready  output  1  high when a sample can be accepted.
REQ-011 SHALL have port mod_signal  output  WI+WF  recovered modulating signal, signed WI.WF.
REQ-012 SHALL have port mod_valid  output  1  one-cycle pulse; mod_signal valid.
REQ-013 SHALL have port sat  output  1  qualified by mod_valid; result was clipped.
REQ-014 SHALL have port div_err  output  1  qualified by mod_valid; denominator was zero.

Function
REQ-015 SHALL accept a sample on the cycle where phase_valid and phase_ready are both high; phase_ready is high only in IDLE.
REQ-016 SHALL have FSM states: IDLE, PRIME, CALC, DIV, DONE.
REQ-017 SHALL, on the first accept after reset, store phase_in as prev_phase, move to PRIME, return to IDLE next cycle, and produce no output.
REQ-018 SHALL, on later accepts, compute delta = phase_in - prev_phase mod 2^NUM_BITS, update prev_phase, and enter CALC.
REQ-019 SHALL, in CALC, form deviation = delta - tuning_word as signed NUM_BITS.
REQ-020 SHALL, in CALC, form denom = (tuning_word * mod_scalar) >> 4 in NUM_BITS+8 bits, saturating to 2^NUM_BITS-1 when it exceeds NUM_BITS bits.
REQ-021 SHALL, in DIV, perform an unsigned restoring division of |deviation| << WF by denom, one quotient bit per cycle, for exactly NUM_BITS+WF cycles.
REQ-022 SHALL apply the sign of deviation to the quotient.
REQ-023 SHALL clip the result to [-2^(WI+WF-1), 2^(WI+WF-1)-1] and set sat when it clips.
REQ-024 SHALL, when denom = 0, skip DIV, drive mod_signal = 0, sat = 0 and div_err = 1.
REQ-025 SHALL, in DONE, pulse mod_valid for one cycle and return to IDLE.
REQ-026 SHALL hold mod_signal, sat and div_err stable until the next mod_valid.
REQ-027 SHALL have latency from accept to mod_valid of NUM_BITS+WF+3 cycles (51 at defaults), or 3 cycles when div_err is set.
REQ-028 SHALL sample tuning_word and mod_scalar only in CALC; changes at other times have no effect on the result in flight.

Reset
REQ-029 SHALL, on rst, drive state = IDLE, phase_ready = 1 (from the next cycle), mod_valid = 0, mod_signal = 0, sat = 0, div_err = 0, prev_phase = 0, primed = 0.
REQ-030 SHALL, on rst mid-operation, abort the division, emit no mod_valid, and treat the next accept as a priming sample.

Configuration
REQ-031 SHALL support macro PHASE_DEMOD_ROUND_EN.
REQ-032 SHALL, when PHASE_DEMOD_ROUND_EN is defined, run one extra DIV iteration and round the magnitude half-up before sign and clip, making latency NUM_BITS+WF+4.
REQ-033 SHALL, when PHASE_DEMOD_ROUND_EN is undefined, truncate the magnitude toward zero.

Structure
REQ-034 SHALL place the FSM state typedef and the constant MOD_SCALAR_WF = 4 in shared package fm_synth_pkg.
REQ-035 SHALL implement the division in sub-module seq_divider, with start/done handshake and parameterised dividend/divisor widths.

Verification (NUM_BITS=32, WI=2, WF=16, no rounding)
REQ-036 SHALL cover: tuning_word=0x01000000, mod_scalar=0x10, phases 0x0, 0x01000000 -> first sample gives no output; second gives mod_signal=0x00000, mod_valid 51 cycles after accept.
REQ-037 SHALL cover: same configuration, next phase 0x02800000 (delta 0x01800000) -> mod_signal=0x08000 (+0.5); next delta 0x00800000 -> 0x38000 (-0.5).
REQ-038 SHALL cover: wrap-around, prev 0xFF800000, next 0x00800000 -> delta 0x01000000, mod_signal=0x00000.
REQ-039 SHALL cover: mod_scalar=0x01, deviation 0x00800000 (true value +8.0) -> mod_signal=0x1FFFF, sat=1.
REQ-040 SHALL cover: mod_scalar=0x00 -> mod_signal=0, div_err=1, mod_valid 3 cycles after accept.
REQ-041 SHALL cover: rst asserted 10 cycles into DIV -> no mod_valid; the next accept only primes.
